// File: rtl/fifo_stream_packer_if.sv
// FIFO read side plus valid/ready/last stream bundle for fifo_stream_packer.
// master = the packer, slave = FIFO/fabric side.
interface fifo_stream_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  r_ready;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;

  modport master (
    input  fifo_empty, fifo_data, m_tready,
    output r_ready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output fifo_empty, fifo_data, m_tready,
    input  r_ready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/fifo_stream_packer.sv
// Pops a show-ahead FIFO into a fixed-length valid/ready/last packet stream.
// Define PACKER_TIMEOUT_EN to zero-pad partial packets after TIMEOUT idle cycles.
module fifo_stream_packer #(
  parameter int DATA_WIDTH    = 32,
  parameter int PKT_LEN       = 4,
  parameter int PKT_CNT_WIDTH = 16,
  parameter int TIMEOUT       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  fifo_stream_packer_if.master     bus,
  output logic                     busy,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

`ifdef PACKER_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } state_e;
  logic [7:0] idle_q, idle_d;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } state_e;
`endif

  state_e                   state_q, state_d;
  logic [CW-1:0]            word_cnt_q, word_cnt_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
  logic                     m_tlast_q, m_tlast_d;

  logic out_free, pop, pad_emit, load, accept, last_word;

  always_comb begin
    out_free  = !m_tvalid_q || bus.m_tready;
    accept    = m_tvalid_q && bus.m_tready;
    last_word = (word_cnt_q == LAST);
`ifdef PACKER_TIMEOUT_EN
    pop      = !reset && !bus.fifo_empty && out_free
               && (state_q != PAD);
    pad_emit = (state_q == PAD) && out_free;
`else
    pop      = !reset && !bus.fifo_empty && out_free;
    pad_emit = 1'b0;
`endif
    load = pop || pad_emit;
  end

  // Datapath: a pop or pad load refills the output stage even on an accept edge.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (accept) begin
      m_tvalid_d = 1'b0;
      if (m_tlast_q) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = pop ? bus.fifo_data : '0;
      m_tlast_d  = last_word;
      word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef PACKER_TIMEOUT_EN
    idle_d = '0;
`endif
    unique case (state_q)
      IDLE: if (pop) state_d = STREAM;
      STREAM: begin
        if (pop && last_word) state_d = IDLE;
`ifdef PACKER_TIMEOUT_EN
        if (!pop) begin
          idle_d = idle_q;
          if (bus.fifo_empty && out_free) begin
            if (idle_q == 8'(TIMEOUT - 1)) begin
              idle_d  = '0;
              state_d = PAD;
            end else begin
              idle_d = idle_q + 8'd1;
            end
          end
        end
`endif
      end
`ifdef PACKER_TIMEOUT_EN
      PAD: if (pad_emit && last_word) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
`ifdef PACKER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.r_ready  = pop;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign busy         = (word_cnt_q != '0);
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Directed bench for fifo_stream_packer with a show-ahead FIFO model.
// PKT_LEN=4, TIMEOUT=8; pad checks follow PACKER_TIMEOUT_EN.
module tb_fifo_stream_packer;
  localparam int DW  = 32;
  localparam int PL  = 4;
  localparam int PCW = 16;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           busy;
  logic [PCW-1:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_stream_packer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_packer #(
    .DATA_WIDTH(DW), .PKT_LEN(PL),
    .PKT_CNT_WIDTH(PCW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  logic [DW-1:0] rx_d[$];
  logic          rx_l[$];
  int            rx_c[$];
  int vecs = 0;
  int errs = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_data  = mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.r_ready) rd_ptr <= rd_ptr + 1;
    if (!reset && bus.m_tvalid && bus.m_tready) begin
      rx_d.push_back(bus.m_tdata);
      rx_l.push_back(bus.m_tlast);
      rx_c.push_back(cyc);
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 60 && rx_d.size() < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    int base;
    bus.m_tready = 1'b1;
    reset = 1'b1;
    push(32'h5A0); push(32'h5A1); push(32'h5A2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.r_ready !== 1'b0 || bus.m_tvalid !== 1'b0 ||
          bus.m_tdata !== '0 || bus.m_tlast !== 1'b0 ||
          busy !== 1'b0 || pkt_cnt !== '0) begin
        errs++;
        $display("FAIL reset_state: rr=%b v=%b d=%h l=%b busy=%b pc=%0d, want all 0",
                 bus.r_ready, bus.m_tvalid, bus.m_tdata, bus.m_tlast, busy, pkt_cnt);
      end
    end
    base = rx_d.size();
    reset = 1'b0;
    #1;
    vecs++;
    if (bus.r_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_pop: r_ready=%b want 1", bus.r_ready);
    end
    @(negedge clk);
    vecs++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h5A0) begin
      errs++;
      $display("FAIL reset_first_word: v=%b d=%h want 1 000005a0",
               bus.m_tvalid, bus.m_tdata);
    end
    wait_rx(base + 3);
    vecs++;
    if (rx_d.size() != base + 3) begin
      errs++;
      $display("FAIL reset_drain: got %0d beats want 3", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (rx_d[base+i] !== 32'h5A0 + i || rx_l[base+i] !== 1'b0) begin
          errs++;
          $display("FAIL reset_drain_beat%0d: d=%h l=%b want %h 0",
                   i, rx_d[base+i], rx_l[base+i], 32'h5A0 + i);
        end
      end
    end
    vecs++;
    if (busy !== 1'b1 || pkt_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_partial: busy=%b pc=%0d want 1 0", busy, pkt_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    int base = rx_d.size();
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    wait_rx(base + 8);
    vecs++;
    if (rx_d.size() != base + 8) begin
      errs++;
      $display("FAIL stream_count: got %0d beats want 8", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vecs++;
        if (rx_d[base+i] !== 32'h10 + i || rx_l[base+i] !== (i == 3 || i == 7) ||
            rx_c[base+i] != rx_c[base] + i) begin
          errs++;
          $display("FAIL stream_beat%0d: d=%h l=%b dt=%0d want %h %b %0d",
                   i, rx_d[base+i], rx_l[base+i], rx_c[base+i] - rx_c[base],
                   32'h10 + i, (i == 3 || i == 7), i);
        end
      end
    end
    vecs++;
    if (pkt_cnt !== 16'd2 || busy !== 1'b0) begin
      errs++;
      $display("FAIL stream_end: pc=%0d busy=%b want 2 0", pkt_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int base = rx_d.size();
    bus.m_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h20 + i);
    @(negedge clk);
    vecs++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h20 || bus.m_tlast !== 1'b0) begin
      errs++;
      $display("FAIL bp_load: v=%b d=%h l=%b want 1 00000020 0",
               bus.m_tvalid, bus.m_tdata, bus.m_tlast);
    end
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (bus.m_tdata !== 32'h20 || bus.r_ready !== 1'b0 ||
          bus.m_tvalid !== 1'b1 || (wr_ptr - rd_ptr) != 3) begin
        errs++;
        $display("FAIL bp_hold%0d: d=%h rr=%b v=%b cnt=%0d want 00000020 0 1 3",
                 i, bus.m_tdata, bus.r_ready, bus.m_tvalid, wr_ptr - rd_ptr);
      end
      @(negedge clk);
    end
    bus.m_tready = 1'b1;
    wait_rx(base + 4);
    vecs++;
    if (rx_d.size() != base + 4) begin
      errs++;
      $display("FAIL bp_count: got %0d beats want 4", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (rx_d[base+i] !== 32'h20 + i || rx_l[base+i] !== (i == 3)) begin
          errs++;
          $display("FAIL bp_beat%0d: d=%h l=%b want %h %b",
                   i, rx_d[base+i], rx_l[base+i], 32'h20 + i, i == 3);
        end
      end
    end
    vecs++;
    if (pkt_cnt !== 16'd3) begin
      errs++;
      $display("FAIL bp_pktcnt: pc=%0d want 3", pkt_cnt);
    end
  endtask

  task automatic test_bubbles();
    int base = rx_d.size();
    push(32'hA0);
    @(negedge clk);
    vecs++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'hA0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL bub_first: v=%b d=%h busy=%b want 1 000000a0 1",
               bus.m_tvalid, bus.m_tdata, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (busy !== 1'b1 || bus.m_tvalid !== 1'b0) begin
        errs++;
        $display("FAIL bub_gap%0d: busy=%b v=%b want 1 0", i, busy, bus.m_tvalid);
      end
    end
    for (int i = 1; i < 4; i++) push(32'hA0 + i);
    wait_rx(base + 4);
    vecs++;
    if (rx_d.size() != base + 4) begin
      errs++;
      $display("FAIL bub_count: got %0d beats want 4", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (rx_d[base+i] !== 32'hA0 + i || rx_l[base+i] !== (i == 3)) begin
          errs++;
          $display("FAIL bub_beat%0d: d=%h l=%b want %h %b",
                   i, rx_d[base+i], rx_l[base+i], 32'hA0 + i, i == 3);
        end
      end
    end
    vecs++;
    if (pkt_cnt !== 16'd4 || busy !== 1'b0) begin
      errs++;
      $display("FAIL bub_end: pc=%0d busy=%b want 4 0", pkt_cnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    int base = rx_d.size();
    push(32'hE0); push(32'hE1);
    wait_rx(base + 2);
    vecs++;
    if (rx_d.size() != base + 2 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mr_partial: beats=%0d busy=%b want 2 1", rx_d.size() - base, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || bus.m_tvalid !== 1'b0 || pkt_cnt !== 16'd0) begin
      errs++;
      $display("FAIL mr_cleared: busy=%b v=%b pc=%0d want 0 0 0",
               busy, bus.m_tvalid, pkt_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    base = rx_d.size();
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    wait_rx(base + 4);
    vecs++;
    if (rx_d.size() != base + 4) begin
      errs++;
      $display("FAIL mr_count: got %0d beats want 4", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (rx_d[base+i] !== 32'hB0 + i || rx_l[base+i] !== (i == 3)) begin
          errs++;
          $display("FAIL mr_beat%0d: d=%h l=%b want %h %b",
                   i, rx_d[base+i], rx_l[base+i], 32'hB0 + i, i == 3);
        end
      end
    end
    vecs++;
    if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mr_end: pc=%0d busy=%b want 1 0", pkt_cnt, busy);
    end
  endtask

  task automatic test_timeout();
    int base = rx_d.size();
    push(32'hC0);
`ifdef PACKER_TIMEOUT_EN
    wait_rx(base + 4);
    vecs++;
    if (rx_d.size() != base + 4) begin
      errs++;
      $display("FAIL to_count: got %0d beats want 4", rx_d.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (rx_d[base+i] !== (i == 0 ? 32'hC0 : 32'h0) || rx_l[base+i] !== (i == 3)) begin
          errs++;
          $display("FAIL to_beat%0d: d=%h l=%b want %h %b", i, rx_d[base+i],
                   rx_l[base+i], (i == 0 ? 32'hC0 : 32'h0), i == 3);
        end
      end
      vecs++;
      if (rx_c[base+1] - rx_c[base] != TO + 1 ||
          rx_c[base+3] - rx_c[base+1] != 2) begin
        errs++;
        $display("FAIL to_timing: gap=%0d span=%0d want %0d 2",
                 rx_c[base+1] - rx_c[base], rx_c[base+3] - rx_c[base+1], TO + 1);
      end
    end
    vecs++;
    if (pkt_cnt !== 16'd2 || busy !== 1'b0) begin
      errs++;
      $display("FAIL to_end: pc=%0d busy=%b want 2 0", pkt_cnt, busy);
    end
`else
    repeat (20) @(negedge clk);
    vecs++;
    if (rx_d.size() != base + 1 || rx_d[base] !== 32'hC0) begin
      errs++;
      $display("FAIL nopad_beats: got %0d beats want 1 (000000c0)", rx_d.size() - base);
    end
    vecs++;
    if (busy !== 1'b1 || bus.m_tvalid !== 1'b0 || pkt_cnt !== 16'd1) begin
      errs++;
      $display("FAIL nopad_state: busy=%b v=%b pc=%0d want 1 0 1",
               busy, bus.m_tvalid, pkt_cnt);
    end
`endif
  endtask

  initial begin
    bus.m_tready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fifo_stream_packer.md
Name: fifo_stream_packer

Overview:
- Downstream consumer of the 32-bit sync FIFO: pops words from the FIFO read side and emits them as a valid/ready/last stream framed into fixed-length packets.
- Sits between the FIFO and the SoC stream fabric (FIR input / DMA sink).
- Keeps a one-entry registered output stage, counts words within a packet and completed packets, and sustains one word per cycle.

Parameters:
- DATA_WIDTH, 32, word width; must match the upstream FIFO WIDTH.
- PKT_LEN, 4, words per packet, 2..256; m_tlast asserts on word PKT_LEN-1.
- PKT_CNT_WIDTH, 16, width of the completed-packet counter.
- TIMEOUT, 8, idle cycles before padding a partial packet (optional feature only), 1..255.

Ports:
- clk, input, 1, single clock, all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- fifo_empty, input, 1, FIFO empty flag; data_out is valid whenever this is 0 (show-ahead FIFO).
- fifo_data, input, DATA_WIDTH, FIFO data_out.
- r_ready, output, 1, FIFO pop strobe; the FIFO pops at the posedge where r_ready=1.
- m_tvalid, output, 1, output word valid.
- m_tready, input, 1, downstream accept.
- m_tdata, output, DATA_WIDTH, output word.
- m_tlast, output, 1, last word of packet.
- busy, output, 1, high while a packet is partially sent (word_cnt != 0).
- pkt_cnt, output, PKT_CNT_WIDTH, completed packets; wraps modulo 2^PKT_CNT_WIDTH.

Behaviour:
- Reset (synchronous, active-high) clears all outputs and state: m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, pkt_cnt=0, word_cnt=0, FSM=IDLE. r_ready=0 while reset=1.
- Reset asserted mid-packet: the partial packet is dropped, no m_tlast is issued, and the next word after reset starts a new packet at word 0.
- Output stage can load when it is free: out_free = !m_tvalid || m_tready.
- Pop rule (combinational): r_ready = !reset && !fifo_empty && out_free && (FSM != PAD).
  - r_ready never asserts while fifo_empty=1, so there is no underflow.
- On a pop posedge:
  - m_tdata <= fifo_data, m_tvalid <= 1, m_tlast <= (word_cnt == PKT_LEN-1).
  - word_cnt increments, wrapping to 0 after PKT_LEN-1.
- Latency: the word present on fifo_data at pop edge k is visible on m_tdata after edge k (1 cycle).
- Throughput: 1 word/cycle with m_tready held high and the FIFO non-empty.
- Hold: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast are stable and no pop occurs.
- Accept edge (m_tvalid && m_tready) with no pop on the same edge: m_tvalid <= 0.
- Simultaneous accept and pop on the same edge: the new word is loaded and m_tvalid stays 1 (no bubble).
- pkt_cnt increments on the accept edge of a word with m_tlast=1.
- busy = (word_cnt != 0).
- FSM:
  - IDLE: word_cnt=0, no packet open. A pop moves to STREAM.
  - STREAM: the pop of word PKT_LEN-1 returns to IDLE.
  - PAD: optional feature only.
- FIFO-empty bubbles inside a packet are legal; m_tvalid simply drops and the packet continues when data returns.
- PKT_LEN=2: tlast alternates on every second word.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles in STREAM with fifo_empty=1 and out_free=1; it resets on any pop.
  - When the counter reaches TIMEOUT, the FSM enters PAD.
  - PAD emits zero words (m_tdata=0) at 1 word/cycle subject to m_tready, advancing word_cnt; the final pad word carries m_tlast=1. The FSM then returns to IDLE.
  - r_ready=0 throughout PAD; FIFO data arriving during PAD waits.
  - reset in PAD returns to IDLE.
- Undefined: no idle counter and no PAD state; partial packets wait indefinitely for FIFO data.

Test Plan:
- Reset check: hold reset 2 cycles with the FIFO holding 3 words -> r_ready=0, m_tvalid=0, pkt_cnt=0; after release, first m_tdata = first FIFO word 1 cycle after the first pop.
- Streaming (PKT_LEN=4): push 8 words 0x10..0x17 with m_tready=1 -> 8 consecutive output beats, m_tlast on 0x13 and 0x17, pkt_cnt=2, busy=0 at end.
- Backpressure: m_tready=0 for 5 cycles while m_tvalid=1 -> m_tdata stable, r_ready=0, FIFO count unchanged; release -> no data lost or duplicated.
- Empty bubbles: feed 0xA0, 3 idle cycles, 0xA1..0xA3 -> m_tlast only on 0xA3, busy=1 during the gap, pkt_cnt=1.
- Mid-packet reset: 2 of 4 words sent, then reset -> next word 0xB0 starts a new packet; m_tlast on the 4th word after reset.
- PACKER_TIMEOUT_EN, TIMEOUT=8: send 0xC0 then FIFO empty -> 8 idle cycles later three 0x0 words, last with m_tlast=1, pkt_cnt increments; undefined build -> no pad words and busy stays 1.
